// File: rtl/dvbc_pkg.sv
// Shared constants and helpers for the DVB-C convolutional interleaver.
// Geometry is fixed: I=12 branches, M=17 bytes per FIFO unit.
package dvbc_pkg;
    localparam int CI_I     = 12;
    localparam int CI_M     = 17;
    localparam int CI_DEPTH = CI_M * CI_I * (CI_I - 1) / 2;
    localparam int CI_AW    = $clog2(CI_DEPTH);

    typedef logic [3:0] ci_branch_t;

    // First RAM byte of branch j; branch j owns j*M consecutive bytes.
    function automatic int ci_base(input int j);
        return CI_M * j * (j - 1) / 2;
    endfunction
endpackage

// File: rtl/ci_ram.sv
// Simple dual-port byte RAM: one write port, one synchronous read port.
// Contents are never cleared.
module ci_ram
    import dvbc_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [CI_AW-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [CI_AW-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [CI_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_interleaver.sv
// Forney convolutional byte interleaver (I=12, M=17) on a shared RAM.
// Two-stage pipeline: RAM read in the first stage, write-back and output mux in the second.
module conv_interleaver
    import dvbc_pkg::*;
(
    input  logic       iClk,
    input  logic       iClrn,
    input  logic       iReq,
    output logic       oReq,
    input  logic       iValid,
    input  logic [7:0] iData,
    input  logic       iPSync,
    output logic       oValid,
    output logic [7:0] oData,
    output logic       oPSync,
    output logic       oResync
);
    ci_branch_t       ptr;
    logic [7:0]       wp [CI_I];
    logic [CI_I-1:0]  filled;

    ci_branch_t       br_p0;
    logic [CI_AW-1:0] addr_p0;
    logic             resync_p0;
    logic             wrap_p0;

    logic             vld_p1;
    ci_branch_t       br_p1;
    logic             psync_p1;
    logic             fill_p1;
    logic             resync_p1;
    logic [7:0]       data_p1;
    logic [CI_AW-1:0] addr_p1;
    logic [7:0]       rd_data;

    // Stage 0: branch selection and RAM address
    always_comb begin
        br_p0     = iPSync ? '0 : ptr;
        addr_p0   = CI_AW'(ci_base(int'(br_p0))) + CI_AW'(wp[br_p0]);
        resync_p0 = iValid & iPSync & (ptr != '0);
        wrap_p0   = (wp[br_p0] == 8'(CI_M * int'(br_p0) - 1));
    end

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            ptr       <= '0;
            filled    <= '0;
            for (int j = 0; j < CI_I; j++) wp[j] <= '0;
            vld_p1    <= 1'b0;
            br_p1     <= '0;
            psync_p1  <= 1'b0;
            fill_p1   <= 1'b0;
            resync_p1 <= 1'b0;
        end else begin
            vld_p1    <= iValid;
            br_p1     <= br_p0;
            psync_p1  <= iValid & iPSync;
            fill_p1   <= filled[br_p0];
            resync_p1 <= resync_p0;
            if (iValid) begin
                ptr <= (br_p0 == ci_branch_t'(CI_I - 1)) ? '0 : br_p0 + 4'd1;
                if (br_p0 != '0) begin
                    if (wrap_p0) begin
                        wp[br_p0]     <= '0;
                        filled[br_p0] <= 1'b1;
                    end else begin
                        wp[br_p0] <= wp[br_p0] + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        data_p1 <= iData;
        addr_p1 <= addr_p0;
    end

    // Read and write address never coincide: adjacent bytes always use different branches.
    ci_ram u_ram (
        .clk   (iClk),
        .we    (vld_p1 && (br_p1 != '0)),
        .waddr (addr_p1),
        .wdata (data_p1),
        .raddr (addr_p0),
        .rdata (rd_data)
    );

    // Stage 1: output mux and registered outputs
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            oReq    <= 1'b0;
            oValid  <= 1'b0;
            oData   <= 8'h00;
            oPSync  <= 1'b0;
            oResync <= 1'b0;
        end else begin
            oReq    <= iReq;
            oValid  <= vld_p1;
            oPSync  <= psync_p1;
            oResync <= resync_p1;
            if (vld_p1) begin
                if (br_p1 == '0)  oData <= data_p1;
                else if (fill_p1) oData <= rd_data;
                else              oData <= 8'h00;
            end
        end
    end
endmodule
